// File: rtl/fetch_queue.sv
// Instruction fetch queue between icache and decode.
// Ports: clk/rst, in_* fetch side, flush, out_* decode side, count.
module fetch_queue #(
  parameter int DEPTH = 4,
  localparam int PTR_WID = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_inst,
  input  logic               in_pred_taken,
  input  logic               in_valid,
  input  logic               icache_stall,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_inst,
  output logic               out_pred_taken,
  output logic [PTR_WID:0]   count
);

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [PTR_WID:0] FULL_CNT = (PTR_WID + 1)'(DEPTH);

  typedef struct packed {
    logic        pt;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t mem [DEPTH];

  logic [PTR_WID-1:0] wr_ptr;
  logic [PTR_WID-1:0] rd_ptr;
  logic [PTR_WID:0]   cnt;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  ent_t head;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);

  assign in_ready  = !full;
  assign out_valid = !empty && !flush;

  assign enq = in_valid && !icache_stall
             && !full && !flush;
  assign deq = out_valid && out_ready;

  assign head = mem[rd_ptr];

  // Idle head reads as a NOP so decode sees
  // a harmless instruction when empty.
  assign out_pc         = empty ? '0  : head.pc;
  assign out_inst       = empty ? NOP : head.inst;
  assign out_pred_taken = empty ? 1'b0 : head.pt;
  assign count          = cnt;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{pt:   in_pred_taken,
                       pc:   in_pc,
                       inst: in_inst};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      unique case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue directly downstream of the instruction cache. Captures {pc, inst, pred_taken} whenever the cache delivers a non-stalled fetch.
- Decouples the fetch stage from decode with a small circular FIFO and a valid/ready handshake toward decode.
- Flushes atomically on branch mispredict. Back-pressures the PC generator through in_ready.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_WID, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low (queue is reset while rst==0).
- in_pc  input  32  pc presented to the instruction cache this cycle.
- in_inst  input  32  instruction returned by the cache.
- in_pred_taken  input  1  branch-predictor taken bit for in_pc.
- in_valid  input  1  fetch stage is presenting a fetch.
- icache_stall  input  1  cache miss in progress; in_inst not yet valid.
- in_ready  output  1  queue can accept an entry (= !full).
- flush  input  1  predict_fail / redirect: discard all contents.
- out_valid  output  1  head entry valid toward decode.
- out_ready  input  1  decode accepts the head entry.
- out_pc  output  32  pc of the head entry.
- out_inst  output  32  instruction of the head entry.
- out_pred_taken  output  1  predicted-taken bit of the head entry.
- count  output  PTR_WID+1  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - Storage array DEPTH x 65 bits, holding {pred_taken, pc, inst}.
  - wr_ptr and rd_ptr, PTR_WID bits each, wrapping modulo DEPTH.
  - cnt, PTR_WID+1 bits.
- Reset (rst==0, asynchronous):
  - wr_ptr=0, rd_ptr=0, cnt=0.
  - Outputs: out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=32'h00000013, out_pred_taken=0.
  - Storage contents need not be reset.
  - Assertion mid-operation discards all entries immediately. Release is synchronised by the normal posedge flow; no special handling.
- Status signals:
  - full = (cnt==DEPTH); empty = (cnt==0).
  - in_ready = !full; combinational from registered cnt, no same-cycle dequeue bypass.
- enq = in_valid && !icache_stall && !full && !flush
  - Writes the entry at wr_ptr on posedge and increments wr_ptr.
- deq = out_valid && out_ready
  - Increments rd_ptr on posedge.
- cnt update:
  - cnt += 1 if enq only.
  - cnt -= 1 if deq only.
  - cnt unchanged if both or neither.
- Simultaneous enq and deq:
  - Legal whenever 0 < cnt < DEPTH.
  - At cnt==DEPTH, enq is blocked (in_ready=0) while deq proceeds; cnt becomes DEPTH-1.
  - At cnt==0, deq is impossible (out_valid=0); enq proceeds.
- Latency:
  - An entry enqueued at posedge N is visible on out_* with out_valid=1 from cycle N+1. No write-through bypass.
  - count reflects the registered cnt.
- Output read path:
  - out_pc, out_inst and out_pred_taken are read combinationally from storage[rd_ptr].
  - When empty: out_inst=32'h00000013 (NOP), out_pc=0, out_pred_taken=0.
- Flush (synchronous):
  - out_valid = !empty && !flush, gated combinationally so decode never consumes during flush.
  - At posedge with flush=1: wr_ptr=rd_ptr=0, cnt=0.
  - A same-cycle enq is dropped. No deq occurs.
  - Flush takes precedence over every other event.
  - The cycle after flush: empty, in_ready=1.
- icache_stall=1: no enqueue, regardless of in_valid. Stall has no effect on dequeue.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 on increment. Ordering must remain FIFO across the wrap.
- No overflow or underflow is possible. The bench asserts cnt never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset then fill: hold out_ready=0 and enqueue pcs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c -> count=4, in_ready=0. A 5th presented pc 0x1c000010 is not stored. out_pc stays 0x1c000000.
- Drain with wrap: continue from full; out_ready=1 while enqueuing 0x1c000010..0x1c00001c -> out_pc sequence 0x1c000000, 0x1c000004, ... strictly increasing, no gaps or duplicates across the pointer wrap. Steady state count=DEPTH-1 with enq+deq in the same cycle.
- Cache stall: in_valid=1, icache_stall=1 for 3 cycles, then 0 with in_inst=0x00a00093 -> count unchanged for 3 cycles, then 1. out_inst=0x00a00093 one cycle after the accepting edge.
- Flush with simultaneous traffic: 3 entries queued, flush=1 with in_valid=1 and out_ready=1 -> out_valid=0 during flush. Next cycle count=0, out_inst=0x00000013, in_ready=1; the flushed-cycle fetch is absent.
- Predict bit passthrough: enqueue pc 0x1c000100 with in_pred_taken=1, then 0x1c000104 with 0 -> out_pred_taken reads 1 then 0, aligned with out_pc.
- Async reset mid-operation: assert rst=0 between clock edges with count=2 -> count=0 and out_valid=0 immediately, without waiting for a posedge. After release, the first enqueue appears at out_pc.
